// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: one single-port RAM shared by the LCD refresh engine
// (fixed priority, bounded latency) and a valid/ready host port.
module fb_arbiter #(
    parameter int MAX_X  = 240,
    parameter int PAGES  = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        lcd_x,
    input  logic [3:0]        lcd_y,
    output logic [7:0]        lcd_pixels,
    output logic              lcd_valid,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int TAG_W = 11;
    localparam logic [ADDR_W-1:0] L_MAX_X = ADDR_W'(MAX_X);
    localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(MAX_X * PAGES);
    localparam logic [8:0]        L_XLIM  = 9'(MAX_X);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LCD_CAP,
        S_HOST_CAP
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_issued_tag;
    logic               r_loaded_ok;
    logic               r_dirty;
    logic               r_rd_oob;

    logic [TAG_W-1:0]   w_cur_tag;
    logic [ADDR_W-1:0]  w_lcd_addr;
    logic [ADDR_W-1:0]  w_tag_addr;
    logic               w_lcd_pend;
    logic               w_lcd_oob;
    logic               w_host_oob;
    logic               w_host_go;
    logic               w_unused_bits;

    // Page bit 3 of lcd_y is not part of the address space.
    assign w_unused_bits = lcd_y[3];

    assign w_cur_tag  = {lcd_y[2:0], lcd_x};
    assign w_lcd_addr = ADDR_W'(lcd_y[2:0]) * L_MAX_X + ADDR_W'(lcd_x);
    assign w_tag_addr = ADDR_W'(r_tag[TAG_W-1:8]) * L_MAX_X
                      + ADDR_W'(r_tag[7:0]);
    assign w_lcd_oob  = ({1'b0, lcd_x} >= L_XLIM);
    assign w_host_oob = (host_addr >= L_DEPTH);

    assign w_lcd_pend = !r_loaded_ok | r_dirty | (r_tag != w_cur_tag);
    assign lcd_valid  = !w_lcd_pend;
    assign host_ready = (r_state == S_IDLE) & !w_lcd_pend & !reset;
    assign w_host_go  = host_ready & host_valid;

    // RAM port is driven only in IDLE; LCD pending always wins the slot.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!reset && r_state == S_IDLE) begin
            if (w_lcd_pend) begin
                if (!w_lcd_oob) begin
                    mem_addr = w_lcd_addr;
                end
            end else if (w_host_go && !w_host_oob) begin
                mem_addr = host_addr;
                if (host_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = host_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_issued_tag <= '0;
            r_loaded_ok  <= 1'b0;
            r_dirty      <= 1'b0;
            r_rd_oob     <= 1'b0;
            lcd_pixels   <= '0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_lcd_pend) begin
                        if (w_lcd_oob) begin
                            lcd_pixels  <= '0;
                            r_tag       <= w_cur_tag;
                            r_loaded_ok <= 1'b1;
                            r_dirty     <= 1'b0;
                        end else begin
                            r_issued_tag <= w_cur_tag;
                            r_state      <= S_LCD_CAP;
                        end
                    end else if (w_host_go) begin
                        if (host_we) begin
                            // Writing the displayed byte forces a re-read.
                            if (!w_host_oob && r_loaded_ok &&
                                host_addr == w_tag_addr) begin
                                r_dirty <= 1'b1;
                            end
                        end else begin
                            r_rd_oob <= w_host_oob;
                            r_state  <= S_HOST_CAP;
                        end
                    end
                end
                S_LCD_CAP: begin
                    lcd_pixels  <= mem_rdata;
                    r_tag       <= r_issued_tag;
                    r_loaded_ok <= 1'b1;
                    r_dirty     <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_HOST_CAP: begin
                    host_rdata  <= r_rd_oob ? 8'h00 : mem_rdata;
                    host_rvalid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous RAM.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  lcd_x;
    logic [3:0]  lcd_y;
    logic [7:0]  lcd_pixels;
    logic        lcd_valid;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:2047];
    int checks = 0;
    int errors = 0;
    int wi;

    fb_arbiter #(.MAX_X(240), .PAGES(8), .ADDR_W(11)) dut (
        .clk(clk), .reset(reset),
        .lcd_x(lcd_x), .lcd_y(lcd_y),
        .lcd_pixels(lcd_pixels), .lcd_valid(lcd_valid),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i * 3 + 1);
        ram[0] = 8'hA5;
        reset = 1'b1; lcd_x = 8'd0; lcd_y = 4'd0;
        host_valid = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;
        tick(); tick();
        #1;
        chk("rst_ready", host_ready, 0);
        chk("rst_lvalid", lcd_valid, 0);
        chk("rst_pix", lcd_pixels, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_mwe", mem_we, 0);
        chk("rst_maddr", mem_addr, 0);

        // First LCD fetch after reset
        reset = 1'b0;
        #1;
        chk("l0_maddr", mem_addr, 0);
        chk("l0_ready", host_ready, 0);
        tick();
        chk("l0_cap_valid", lcd_valid, 0);
        tick();
        chk("l0_pix", lcd_pixels, 8'hA5);
        chk("l0_valid", lcd_valid, 1);
        wi = 0;
        for (int i = 0; i < 4; i++) begin
            if (!host_ready) wi++;
            tick();
        end
        chk("l0_hold_noread", wi, 0);

        // Host write to the displayed byte
        lcd_x = 8'd5; lcd_y = 4'd1;
        #1;
        chk("l1_maddr", mem_addr, 245);
        chk("l1_valid0", lcd_valid, 0);
        tick(); tick();
        chk("l1_pix", lcd_pixels, 8'hE0);
        chk("l1_valid", lcd_valid, 1);
        host_valid = 1'b1; host_we = 1'b1;
        host_addr = 11'd245; host_wdata = 8'h3C;
        #1;
        chk("w_ready", host_ready, 1);
        chk("w_mwe", mem_we, 1);
        chk("w_maddr", mem_addr, 245);
        chk("w_mwdata", mem_wdata, 8'h3C);
        tick();
        host_valid = 1'b0; host_we = 1'b0;
        #1;
        chk("w_dirty_valid", lcd_valid, 0);
        chk("w_reread_addr", mem_addr, 245);
        chk("w_mwe_off", mem_we, 0);
        tick(); tick();
        chk("w_pix", lcd_pixels, 8'h3C);
        chk("w_valid", lcd_valid, 1);

        // Host read while LCD moves during HOST_CAP
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd10;
        #1;
        chk("r_ready", host_ready, 1);
        chk("r_maddr", mem_addr, 10);
        tick();
        host_valid = 1'b0; lcd_x = 8'd7;
        #1;
        chk("r_cap_ready", host_ready, 0);
        chk("r_cap_rvalid", host_rvalid, 0);
        chk("r_cap_lvalid", lcd_valid, 0);
        tick();
        chk("r_rvalid", host_rvalid, 1);
        chk("r_rdata", host_rdata, 8'h1F);
        chk("r_lcd_grant", mem_addr, 247);
        tick();
        chk("r_rvalid_pulse", host_rvalid, 0);
        tick();
        chk("r_lpix", lcd_pixels, 8'hE6);
        chk("r_lvalid", lcd_valid, 1);

        // Streaming host writes with LCD stepping every 8 clocks
        wi = 0;
        host_we = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k % 8 == 0) begin
                lcd_x = 8'(20 + k / 8); lcd_y = 4'd0;
            end
            host_valid = (wi < 8);
            host_addr  = 11'(100 + wi);
            host_wdata = 8'(8'h80 + wi);
            #1;
            chk("s_ready", host_ready, (k % 8) >= 2);
            chk("s_lvalid", lcd_valid, (k % 8) >= 2);
            if (host_ready && host_valid) wi++;
            tick();
        end
        host_valid = 1'b0; host_we = 1'b0;
        chk("s_count", wi, 8);
        for (int i = 0; i < 8; i++)
            chk("s_ram", ram[100 + i], 8'(8'h80 + i));
        chk("s_lpix", lcd_pixels, 8'd64);

        // Out-of-range LCD column and host address
        lcd_x = 8'd240; lcd_y = 4'd0;
        #1;
        chk("o_lvalid0", lcd_valid, 0);
        chk("o_mwe", mem_we, 0);
        tick();
        chk("o_pix", lcd_pixels, 0);
        chk("o_lvalid", lcd_valid, 1);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd1920;
        #1;
        chk("o_rd_ready", host_ready, 1);
        chk("o_rd_maddr", mem_addr, 0);
        tick();
        host_valid = 1'b0;
        #1;
        chk("o_rd_rv0", host_rvalid, 0);
        tick();
        chk("o_rd_rvalid", host_rvalid, 1);
        chk("o_rd_rdata", host_rdata, 0);
        host_valid = 1'b1; host_we = 1'b1; host_wdata = 8'hFF;
        #1;
        chk("o_wr_ready", host_ready, 1);
        chk("o_wr_mwe", mem_we, 0);
        tick();
        host_valid = 1'b0; host_we = 1'b0;

        // Reset during HOST_CAP
        lcd_x = 8'd3; lcd_y = 4'd0;
        tick(); tick();
        chk("x_pix", lcd_pixels, 8'h0A);
        host_valid = 1'b1; host_addr = 11'd10;
        #1;
        chk("x_ready", host_ready, 1);
        tick();
        host_valid = 1'b0; reset = 1'b1;
        #1;
        chk("x_rst_ready", host_ready, 0);
        tick();
        chk("x_rvalid", host_rvalid, 0);
        chk("x_pix_rst", lcd_pixels, 0);
        chk("x_lvalid", lcd_valid, 0);
        chk("x_maddr_rst", mem_addr, 0);
        reset = 1'b0;
        #1;
        chk("x_reissue", mem_addr, 3);
        tick();
        chk("x_rvalid2", host_rvalid, 0);
        tick();
        chk("x_pix2", lcd_pixels, 8'h0A);
        chk("x_lvalid2", lcd_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (240 columns x 8 pages x 8 bits = 1920 bytes) between two requesters:
  - the LCD refresh engine, which presents x/y and expects a pixel byte;
  - a host port, which writes and reads the framebuffer.
- LCD reads have fixed priority and bounded latency. Host accesses are serviced with a valid/ready handshake in the remaining slots.
- Host writes to the byte currently shown to the LCD trigger a coherent re-read.

Parameters:
- MAX_X, 240, columns per page; LCD x at or above this is out of range.
- PAGES, 8, pages; framebuffer depth is MAX_X*PAGES.
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= MAX_X*PAGES.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- lcd_x  in  8  LCD column request.
- lcd_y  in  4  LCD page request; bits [2:0] used, bit 3 ignored.
- lcd_pixels  out  8  registered pixel byte for the loaded address.
- lcd_valid  out  1  lcd_pixels matches the current lcd_x/lcd_y and is not stale.
- host_valid  in  1  host request.
- host_ready  out  1  arbiter accepts the host request this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  byte address, computed as page*MAX_X+column.
- host_wdata  in  8  write data.
- host_rdata  out  8  read data.
- host_rvalid  out  1  one-cycle pulse; host_rdata is valid.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid one cycle after the address.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: lcd_pixels=0, lcd_valid=0, host_rdata=0, host_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, loaded_ok=0, dirty=0.
- host_ready=0 during reset.
- LCD address: lcd_addr = lcd_y[2:0]*MAX_X + lcd_x, width ADDR_W, no overflow for in-range inputs.
  - lcd_oob = (lcd_x >= MAX_X).
- LCD tag: a loaded tag {lcd_y[2:0], lcd_x} plus flags loaded_ok and dirty.
  - lcd_pend (combinational) = !loaded_ok | dirty | (tag != current {lcd_y[2:0], lcd_x}).
  - lcd_valid = !lcd_pend.
- host_ready (combinational) = (state==IDLE) & !lcd_pend & !reset.
- mem_* outputs are combinational from state and the grant. They are 0 in all other cycles.
- State IDLE:
  - If lcd_pend and lcd_oob: lcd_pixels<=0; tag<=current; loaded_ok<=1; dirty<=0; stay in IDLE. No RAM access.
  - Else if lcd_pend: mem_addr=lcd_addr; latch issued tag; go to LCD_CAP.
  - Else if host_valid (handshake fires) and host_we: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata; stay in IDLE.
    - Back-to-back host writes are allowed, one per cycle.
    - If host_addr equals the address of the loaded tag and loaded_ok=1, set dirty<=1.
  - Else if host_valid and !host_we: mem_addr=host_addr; go to HOST_CAP.
- State LCD_CAP: lcd_pixels<=mem_rdata; tag<=issued tag; loaded_ok<=1; dirty<=0; go to IDLE.
  - If lcd_x/lcd_y changed during this cycle, lcd_pend is re-evaluated against the new tag. lcd_valid stays 0 and a new read follows.
- State HOST_CAP: host_rdata<=mem_rdata; host_rvalid<=1 for one cycle, visible the following cycle; go to IDLE.
- Out-of-range host_addr (>= MAX_X*PAGES):
  - Write is accepted, mem_we=0, no effect.
  - Read is accepted, returns host_rdata=0 with host_rvalid after the normal latency. No RAM access.
- Latency:
  - LCD address change at cycle t gives lcd_pixels updated and lcd_valid=1 by cycle t+3 worst case (a HOST_CAP in progress). Best case is t+2.
  - Host write: zero wait when the LCD is idle.
  - Host read: host_rvalid two cycles after acceptance.
- Starvation: the host waits only while lcd_pend. Since the LCD changes address at most once per 8 clocks, the host is guaranteed at least 5 grant slots per LCD change.
- Reset mid-operation: any in-flight read is abandoned, no host_rvalid is generated, and the state returns to IDLE with loaded_ok=0.

Test Plan:
- Reset, then lcd_x=0, lcd_y=0 with RAM[0]=0xA5 -> mem_addr=0 in the first IDLE cycle; lcd_pixels=0xA5 and lcd_valid=1 two cycles later; no further RAM reads while x/y are held.
- Host writes 0x3C to addr 245 with the LCD stable on x=5, y=1 (addr 245) -> mem_we pulse; dirty set; lcd_valid drops; re-read gives lcd_pixels=0x3C within 3 cycles.
- Host read of addr 10 issued, LCD moves to x=7 in the same cycle -> host_rvalid with RAM[10] two cycles after acceptance; LCD read granted in the next IDLE; lcd_valid within 3 cycles of the x change.
- host_valid held high with 8 back-to-back writes, LCD address stepping every 8 clocks -> host_ready drops only on LCD-pending cycles; all 8 writes land; LCD latency never exceeds 3.
- lcd_x=240 -> no RAM access, lcd_pixels=0x00, lcd_valid=1 next cycle. Host read of addr 1920 -> host_rdata=0x00 with host_rvalid; mem_we never asserted.
- Assert reset during HOST_CAP -> no host_rvalid; all outputs at reset values; the first LCD read is reissued after reset deasserts.
